byte_unloader: RTL

//  Parallel-to-serial unloader for wide activation/weight words. Takes one WIDTH-bit word

---
 rtl/lpaccel_pkg.sv | 5 +
 rtl/byte_unloader.sv | 55 +++++
 2 files changed

// File: rtl/lpaccel_pkg.sv
// lpaccel_pkg: shared byte width and unloader state type for the wide-bank readout path
package lpaccel_pkg;
  localparam int BW_DEFAULT = 8;
  typedef enum logic {IDLE, SEND} unload_state_e;
endpackage

// File: rtl/byte_unloader.sv
// byte_unloader: accepts one WIDTH-bit word and streams it out as BW-bit bytes, MSB byte first
module byte_unloader
  import lpaccel_pkg::*;
#(
  parameter int WIDTH = 2048,
  parameter int BW    = BW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BW-1:0]    out_data_o,
  output logic             out_last_o,
  output logic             busy_o
);
  localparam int NBYTES = WIDTH / BW;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);
  if (WIDTH % BW != 0 || WIDTH / BW < 2) begin : g_bad_params
    $error("byte_unloader: WIDTH must be a multiple of BW with at least two bytes");
  end
  unload_state_e    state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             send, load, adv, fin;
  assign send        = state_q == SEND;
  assign out_valid_o = send;
  assign busy_o      = send;
  assign out_last_o  = send & (cnt_q == LAST);
  assign out_data_o  = send ? shreg_q[WIDTH-1 -: BW] : '0;
  // Combinational from out_ready_i so a new word can load on the last-byte cycle without a bubble
  assign in_ready_o  = ~send | (out_last_o & out_ready_i);
  assign load        = in_valid_i & in_ready_o;
  assign adv         = send & out_ready_i;
  assign fin         = adv & out_last_o;
  always_comb begin
    shreg_d = load ? in_data_i : fin ? '0 : adv ? shreg_q << BW : shreg_q;
    cnt_d   = (load | fin) ? '0 : adv ? cnt_q + CNT_W'(1) : cnt_q;
    state_d = load ? SEND : fin ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
